// File: rtl/temporizador_mmss.sv
// MM:SS countdown timer feeding the seven-segment decoder with four BCD digits.
// Counts down once per TICKS_PER_SEC clocks; supports load, start, pause/resume and a 00:00 pulse.
//
// state  | meaning
// IDLE   | preset loaded or cleared, waiting for start
// RUN    | prescaler advancing, one-second decrements applied
// PAUSED | digits and prescaler frozen, resume keeps prescaler progress
// DONE   | count reached 00:00, waiting for a new load
module temporizador_mmss #(
    parameter int TICKS_PER_SEC = 50_000_000,
    parameter int PRESC_W       = 26
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] load_min_dez,
    input  logic [3:0] load_min_uni,
    input  logic [3:0] load_seg_dez,
    input  logic [3:0] load_seg_uni,
    input  logic       start,
    input  logic       pause,
    output logic [3:0] minutos_dez,
    output logic [3:0] minutos_uni,
    output logic [3:0] segundos_dez,
    output logic [3:0] segundos_uni,
    output logic       running,
    output logic       fim
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_PAUSED = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICKS_PER_SEC - 1);
    localparam logic [PRESC_W-1:0] PRESC_ZERO = '0;
    localparam logic [PRESC_W-1:0] PRESC_ONE  = PRESC_W'(1);

    state_t             state_q;
    state_t             state_d;
    logic [PRESC_W-1:0] presc_q;
    logic [PRESC_W-1:0] presc_d;
    logic [3:0]         md_d, mu_d, sd_d, su_d;
    logic               running_d;
    logic               fim_d;

    logic [3:0]         ld_md, ld_mu, ld_sd, ld_su;
    logic [3:0]         dec_md, dec_mu, dec_sd, dec_su;
    logic               tick;
    logic               is_zero;
    logic               is_one;

    // Presets are clamped so the digits always hold a legal MM:SS value.
    assign ld_md = (load_min_dez > 4'd9) ? 4'd9 : load_min_dez;
    assign ld_mu = (load_min_uni > 4'd9) ? 4'd9 : load_min_uni;
    assign ld_sd = (load_seg_dez > 4'd5) ? 4'd5 : load_seg_dez;
    assign ld_su = (load_seg_uni > 4'd9) ? 4'd9 : load_seg_uni;

    assign tick    = (presc_q == PRESC_LAST);
    assign is_zero = (minutos_dez == 4'd0) && (minutos_uni == 4'd0) &&
                     (segundos_dez == 4'd0) && (segundos_uni == 4'd0);
    assign is_one  = (minutos_dez == 4'd0) && (minutos_uni == 4'd0) &&
                     (segundos_dez == 4'd0) && (segundos_uni == 4'd1);

    // One-second BCD decrement; only consumed in RUN, where the count is never 00:00.
    always_comb begin
        dec_md = minutos_dez;
        dec_mu = minutos_uni;
        dec_sd = segundos_dez;
        dec_su = segundos_uni;
        if (segundos_uni != 4'd0) begin
            dec_su = segundos_uni - 4'd1;
        end else begin
            dec_su = 4'd9;
            if (segundos_dez != 4'd0) begin
                dec_sd = segundos_dez - 4'd1;
            end else begin
                dec_sd = 4'd5;
                if (minutos_uni != 4'd0) begin
                    dec_mu = minutos_uni - 4'd1;
                end else begin
                    dec_mu = 4'd9;
                    dec_md = minutos_dez - 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            presc_q      <= PRESC_ZERO;
            minutos_dez  <= 4'd0;
            minutos_uni  <= 4'd0;
            segundos_dez <= 4'd0;
            segundos_uni <= 4'd0;
            running      <= 1'b0;
            fim          <= 1'b0;
        end else begin
            state_q      <= state_d;
            presc_q      <= presc_d;
            minutos_dez  <= md_d;
            minutos_uni  <= mu_d;
            segundos_dez <= sd_d;
            segundos_uni <= su_d;
            running      <= running_d;
            fim          <= fim_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (!load && start) begin
                    state_d = is_zero ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                // Reaching 00:00 outranks a simultaneous pause.
                if (tick && is_one) begin
                    state_d = S_DONE;
                end else if (pause) begin
                    state_d = S_PAUSED;
                end
            end
            S_PAUSED: begin
                if (load) begin
                    state_d = S_IDLE;
                end else if (start) begin
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                if (load) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        presc_d   = presc_q;
        md_d      = minutos_dez;
        mu_d      = minutos_uni;
        sd_d      = segundos_dez;
        su_d      = segundos_uni;
        fim_d     = 1'b0;
        running_d = (state_d == S_RUN);
        case (state_q)
            S_IDLE: begin
                if (load) begin
                    md_d = ld_md;
                    mu_d = ld_mu;
                    sd_d = ld_sd;
                    su_d = ld_su;
                end else if (start) begin
                    presc_d = PRESC_ZERO;
                    fim_d   = is_zero;
                end
            end
            S_RUN: begin
                if (tick) begin
                    presc_d = PRESC_ZERO;
                    md_d    = dec_md;
                    mu_d    = dec_mu;
                    sd_d    = dec_sd;
                    su_d    = dec_su;
                    fim_d   = is_one;
                end else if (!pause) begin
                    presc_d = presc_q + PRESC_ONE;
                end
            end
            S_PAUSED: begin
                if (load) begin
                    presc_d = PRESC_ZERO;
                    md_d    = ld_md;
                    mu_d    = ld_mu;
                    sd_d    = ld_sd;
                    su_d    = ld_su;
                end
            end
            S_DONE: begin
                if (load) begin
                    md_d = ld_md;
                    mu_d = ld_mu;
                    sd_d = ld_sd;
                    su_d = ld_su;
                end
            end
            default: begin
                presc_d = PRESC_ZERO;
            end
        endcase
    end

endmodule

// File: tb/tb_temporizador_mmss.sv
// Bench for temporizador_mmss at four ticks per second: hand vectors, corner sequences,
// and random stimulus against a seconds-based reference model.
module tb_temporizador_mmss;

    localparam int T = 4;

    logic       clk = 1'b0;
    logic       rst_n, load, start, pause;
    logic [3:0] l_md, l_mu, l_sd, l_su;
    logic [3:0] minutos_dez, minutos_uni, segundos_dez, segundos_uni;
    logic       running, fim;
    logic [15:0] dig;

    always #5 clk = ~clk;

    temporizador_mmss #(.TICKS_PER_SEC(T), .PRESC_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .load(load),
        .load_min_dez(l_md), .load_min_uni(l_mu),
        .load_seg_dez(l_sd), .load_seg_uni(l_su),
        .start(start), .pause(pause),
        .minutos_dez(minutos_dez), .minutos_uni(minutos_uni),
        .segundos_dez(segundos_dez), .segundos_uni(segundos_uni),
        .running(running), .fim(fim)
    );

    assign dig = {minutos_dez, minutos_uni, segundos_dez, segundos_uni};

    int tests = 0;
    int fails = 0;

    // Reference model: remaining time as plain seconds, mode 0 idle/1 run/2 paused/3 done.
    int   m_secs = 0;
    int   m_mode = 0;
    int   m_prog = 0;
    logic m_run  = 1'b0;
    logic m_fim  = 1'b0;

    function automatic int clampv(input logic [3:0] x, input int lim);
        return (int'(x) > lim) ? lim : int'(x);
    endfunction

    function automatic int preset_secs();
        return (clampv(l_md, 9) * 10 + clampv(l_mu, 9)) * 60 + clampv(l_sd, 5) * 10 + clampv(l_su, 9);
    endfunction

    function automatic logic [15:0] secs_bcd(input int s);
        int m, r;
        m = s / 60;
        r = s % 60;
        return {4'(m / 10), 4'(m % 10), 4'(r / 10), 4'(r % 10)};
    endfunction

    task automatic model_step();
        m_fim = 1'b0;
        if (!rst_n) begin
            m_secs = 0; m_mode = 0; m_prog = 0;
        end else begin
            case (m_mode)
                0: if (load) m_secs = preset_secs();
                   else if (start) begin
                       if (m_secs > 0) begin m_mode = 1; m_prog = 0; end
                       else begin m_mode = 3; m_fim = 1'b1; end
                   end
                1: if (m_prog == T - 1) begin
                       m_prog = 0;
                       m_secs = m_secs - 1;
                       if (m_secs == 0) begin m_mode = 3; m_fim = 1'b1; end
                       else if (pause) m_mode = 2;
                   end else if (pause) m_mode = 2;
                   else m_prog = m_prog + 1;
                2: if (load) begin m_secs = preset_secs(); m_prog = 0; m_mode = 0; end
                   else if (start) m_mode = 1;
                3: if (load) begin m_secs = preset_secs(); m_mode = 0; end
                default: m_mode = 0;
            endcase
        end
        m_run = (m_mode == 1);
    endtask

    task automatic step(input logic r, input logic l, input logic [15:0] ld, input logic s, input logic p);
        rst_n = r; load = l; {l_md, l_mu, l_sd, l_su} = ld; start = s; pause = p;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic        r;
        logic        l;
        logic [15:0] ld;
        logic        s;
        logic        p;
        logic [15:0] e_dig;
        logic        e_run;
        logic        e_fim;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic l, input logic [15:0] ld, input logic s,
                                input logic p, input logic [15:0] ed, input logic er, input logic ef);
        vec_t v;
        v.r = r; v.l = l; v.ld = ld; v.s = s; v.p = p;
        v.e_dig = ed; v.e_run = er; v.e_fim = ef;
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t vecs[33];
        int   fim_at;
        logic [15:0] ld;

        rst_n = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0;
        l_md = 4'h0; l_mu = 4'h0; l_sd = 4'h0; l_su = 4'h0;

        //              rst load ld       st pa  dig      run fim
        vecs[0]  = mk(0, 0, 16'h0000, 1, 0, 16'h0000, 0, 0);
        vecs[1]  = mk(0, 0, 16'h0000, 1, 0, 16'h0000, 0, 0);
        vecs[2]  = mk(1, 1, 16'h9959, 0, 0, 16'h9959, 0, 0);
        vecs[3]  = mk(1, 1, 16'hFFFF, 0, 0, 16'h9959, 0, 0);
        vecs[4]  = mk(1, 1, 16'h786A, 0, 0, 16'h7859, 0, 0);
        vecs[5]  = mk(1, 1, 16'h0105, 1, 0, 16'h0105, 0, 0);
        vecs[6]  = mk(1, 0, 16'h0000, 1, 0, 16'h0105, 1, 0);
        vecs[7]  = mk(1, 0, 16'h0000, 0, 0, 16'h0105, 1, 0);
        vecs[8]  = mk(1, 0, 16'h0000, 0, 0, 16'h0105, 1, 0);
        vecs[9]  = mk(1, 0, 16'h0000, 0, 0, 16'h0105, 1, 0);
        vecs[10] = mk(1, 0, 16'h0000, 0, 0, 16'h0104, 1, 0);
        vecs[11] = mk(1, 1, 16'h9999, 0, 0, 16'h0104, 1, 0);
        vecs[12] = mk(1, 0, 16'h0000, 1, 0, 16'h0104, 1, 0);
        vecs[13] = mk(1, 0, 16'h0000, 0, 1, 16'h0104, 0, 0);
        vecs[14] = mk(1, 1, 16'h0001, 1, 0, 16'h0001, 0, 0);
        vecs[15] = mk(1, 0, 16'h0000, 1, 0, 16'h0001, 1, 0);
        vecs[16] = mk(1, 0, 16'h0000, 0, 0, 16'h0001, 1, 0);
        vecs[17] = mk(1, 0, 16'h0000, 0, 0, 16'h0001, 1, 0);
        vecs[18] = mk(1, 0, 16'h0000, 0, 0, 16'h0001, 1, 0);
        vecs[19] = mk(1, 0, 16'h0000, 0, 0, 16'h0000, 0, 1);
        vecs[20] = mk(1, 0, 16'h0000, 0, 0, 16'h0000, 0, 0);
        vecs[21] = mk(1, 0, 16'h0000, 1, 0, 16'h0000, 0, 0);
        vecs[22] = mk(1, 1, 16'h1000, 0, 0, 16'h1000, 0, 0);
        vecs[23] = mk(1, 0, 16'h0000, 1, 0, 16'h1000, 1, 0);
        vecs[24] = mk(1, 0, 16'h0000, 0, 0, 16'h1000, 1, 0);
        vecs[25] = mk(1, 0, 16'h0000, 0, 0, 16'h1000, 1, 0);
        vecs[26] = mk(1, 0, 16'h0000, 0, 0, 16'h1000, 1, 0);
        vecs[27] = mk(1, 0, 16'h0000, 0, 0, 16'h0959, 1, 0);
        vecs[28] = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0);
        vecs[29] = mk(1, 0, 16'h0000, 1, 0, 16'h0000, 0, 1);
        vecs[30] = mk(1, 0, 16'h0000, 0, 0, 16'h0000, 0, 0);
        vecs[31] = mk(1, 1, 16'h0000, 0, 0, 16'h0000, 0, 0);
        vecs[32] = mk(1, 0, 16'h0000, 1, 0, 16'h0000, 0, 1);

        for (int i = 0; i < 33; i++) begin
            step(vecs[i].r, vecs[i].l, vecs[i].ld, vecs[i].s, vecs[i].p);
            chk($sformatf("vec%0d digits", i), dig, vecs[i].e_dig);
            chk($sformatf("vec%0d running", i), {15'b0, running}, {15'b0, vecs[i].e_run});
            chk($sformatf("vec%0d fim", i), {15'b0, fim}, {15'b0, vecs[i].e_fim});
        end

        // 01:00 runs to completion in 60 seconds of ticks.
        step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        step(1'b1, 1'b1, 16'h0100, 1'b0, 1'b0);
        step(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        fim_at = -1;
        for (int c = 1; c <= 300; c++) begin
            idle();
            if (c == 4) chk("full 00:59 after first second", dig, 16'h0059);
            if (fim) begin
                fim_at = c;
                break;
            end
        end
        chk_int("full cycles to fim", fim_at, 60 * T);
        chk("full digits at fim", dig, 16'h0000);
        chk("full running at fim", {15'b0, running}, 16'h0000);
        idle();
        chk("full fim one cycle", {15'b0, fim}, 16'h0000);

        // Pause keeps prescaler progress across a long hold.
        step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        step(1'b1, 1'b1, 16'h0005, 1'b0, 1'b0);
        step(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        idle();
        idle();
        step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b1);
        chk("pause running low", {15'b0, running}, 16'h0000);
        repeat (10) idle();
        chk("pause digits held", dig, 16'h0005);
        step(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        chk("resume running", {15'b0, running}, 16'h0001);
        idle();
        chk("resume +1 no decrement", dig, 16'h0005);
        idle();
        chk("resume +2 decrement", dig, 16'h0004);

        // Tick and pause on the same edge: decrement, then paused with prescaler cleared.
        step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        step(1'b1, 1'b1, 16'h0003, 1'b0, 1'b0);
        step(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        repeat (3) idle();
        step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b1);
        chk("tick+pause digits", dig, 16'h0002);
        chk("tick+pause running", {15'b0, running}, 16'h0000);
        repeat (5) idle();
        step(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        repeat (3) idle();
        chk("tick+pause resume +3", dig, 16'h0002);
        idle();
        chk("tick+pause resume +4", dig, 16'h0001);

        // Reaching 00:00 under pause ends in DONE.
        step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        step(1'b1, 1'b1, 16'h0001, 1'b0, 1'b0);
        step(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        repeat (3) idle();
        step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b1);
        chk("zero+pause digits", dig, 16'h0000);
        chk("zero+pause fim", {15'b0, fim}, 16'h0001);
        chk("zero+pause running", {15'b0, running}, 16'h0000);
        step(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        chk("done ignores start fim", {15'b0, fim}, 16'h0000);
        chk("done ignores start running", {15'b0, running}, 16'h0000);

        // Random stimulus against the model.
        for (int i = 0; i < 4000; i++) begin
            ld = {4'($urandom_range(0, 1)), 4'($urandom_range(0, 2)),
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))};
            step(($urandom_range(0, 299) != 0), ($urandom_range(0, 29) == 0), ld,
                 ($urandom_range(0, 5) == 0), ($urandom_range(0, 9) == 0));
            chk("rnd digits", dig, secs_bcd(m_secs));
            chk("rnd running", {15'b0, running}, {15'b0, m_run});
            chk("rnd fim", {15'b0, fim}, {15'b0, m_fim});
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/temporizador_mmss.md
# temporizador_mmss

Countdown timer that generates the four BCD digits (tens/units of minutes, tens/units of seconds) consumed by the seven-segment display decoder. It is the source end of the display's minutes/seconds interface. It loads a preset MM:SS value, counts down once per second from a prescaled system clock, and supports start, pause and resume. On reaching 00:00 it emits a one-cycle completion pulse.

## Interface
- `TICKS_PER_SEC`, default 50_000_000: clock cycles per one-second decrement; must be ≥2.
- `PRESC_W`, default 26: prescaler width; must satisfy 2^PRESC_W ≥ TICKS_PER_SEC.
- `clk` in 1: system clock; all logic on the rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `load` in 1: capture the `load_*` digits as the new preset.
- `load_min_dez` in 4: BCD tens of minutes.
- `load_min_uni` in 4: BCD units of minutes.
- `load_seg_dez` in 4: BCD tens of seconds.
- `load_seg_uni` in 4: BCD units of seconds.
- `start` in 1: begin or resume counting.
- `pause` in 1: suspend counting.
- `minutos_dez` out 4: current tens of minutes, BCD, registered.
- `minutos_uni` out 4: current units of minutes, BCD, registered.
- `segundos_dez` out 4: current tens of seconds, BCD, registered.
- `segundos_uni` out 4: current units of seconds, BCD, registered.
- `running` out 1: high while in RUN.
- `fim` out 1: one-cycle pulse when the count reaches 00:00.

## Operation
- Reset (`rst_n`=0 at an edge): state IDLE; all digits 0; prescaler 0; `running`=0; `fim`=0. Reset overrides every other input, including mid-count.
- Load clamping: digit inputs are clamped at capture. `load_min_dez`, `load_min_uni` and `load_seg_uni` values >9 become 9; `load_seg_dez` >5 becomes 5. The maximum preset is therefore 99:59.
- States: IDLE, RUN, PAUSED, DONE.
- IDLE:
  - `load` captures the digits.
  - `start` with a nonzero count goes to RUN and clears the prescaler.
  - `start` at 00:00 goes to DONE and pulses `fim`.
  - If `load` and `start` are high together, `load` wins and `start` is ignored; the state stays IDLE.
- RUN:
  - The prescaler counts 0..TICKS_PER_SEC−1. At the terminal count it wraps to 0 and the value is decremented by one second.
  - Borrow chain: units of seconds 0→9 borrows from tens of seconds; tens of seconds 0→5 borrows from units of minutes; units of minutes 0→9 borrows from tens of minutes.
  - If the decrement yields 00:00, go to DONE and set `fim`=1 for that cycle only.
  - `pause` goes to PAUSED; the prescaler value is held, not cleared.
  - `load` and `start` are ignored in RUN.
- PAUSED:
  - Digits and prescaler are frozen.
  - `start` returns to RUN and continues from the held prescaler value.
  - `load` captures new digits, clears the prescaler and goes to IDLE.
  - If `load` and `start` are high together, `load` wins.
- DONE:
  - Digits hold 00:00; `running`=0; `start` is ignored.
  - `load` captures new digits and goes to IDLE.
- Simultaneous tick and `pause` in RUN: the decrement is applied, then the state goes to PAUSED with the prescaler at 0.
- If the tick reaches 00:00 while `pause` is high, DONE takes priority over PAUSED.
- The count never wraps below 00:00; no decrement occurs outside RUN.

## Timing
- All outputs are registered. There is no combinational path from any input to any output.
- A `start` sampled at edge k sets `running`=1 after edge k. The first decrement becomes visible after edge k+TICKS_PER_SEC. Each later decrement follows every TICKS_PER_SEC cycles.
- `pause` sampled at edge p: `running`=0 after edge p, and no decrement is visible after edge p.
- On resume, the remaining cycles to the next decrement are TICKS_PER_SEC minus the prescaler progress held at pause.
- `fim` is high for exactly one cycle: the cycle after the edge where digits become 00:00. `running` falls on the same edge.
- `load` updates the digits on the edge after it is sampled, in every state where `load` is accepted.
- Total duration from start to `fim` for preset N seconds (N≥1), with no pause: N×TICKS_PER_SEC cycles.

## Test plan
(Bench uses TICKS_PER_SEC=4.)
- Reset, then hold `rst_n`=0 with `start`=1 → digits 0000, `running`=0, `fim`=0 throughout.
- Load 01:00, start → after 4 cycles digits read 00:59; after 240 cycles total, `fim` pulses for 1 cycle, digits read 00:00, `running`=0.
- Load 10:00, start, run 4 cycles → digits read 09:59 (full borrow chain). Load 99:59 → digits accepted unchanged. Load F:F:F:F → digits read 99:59.
- Load 00:05, start, pause after 2 cycles, hold paused 10 cycles, start → next decrement to 00:04 occurs 2 cycles after resume.
- `load`+`start` together in IDLE → state stays IDLE, `running`=0. `start` at 00:00 → `fim` pulses once and `running` never rises.
- Load 00:03, start, assert `rst_n`=0 mid-count → next cycle digits 0000, state IDLE; a subsequent `start` at 00:00 gives a `fim` pulse.
